wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter_pkg.sv | 29 ++
 rtl/wb_port_arbiter_if.sv | 46 ++++
 rtl/wb_port_arbiter_fifo.sv | 63 ++++++
 rtl/wb_port_arbiter.sv | 116 +++++++++++
 tb/tb_wb_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Holds width defaults, the pending-entry record and the FSM states.
package wb_arb_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int STARVE_LIMIT   = 4;

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0]     wdata;
    } pend_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        STARVE
    } arb_state_t;

    // Register 0 never creates a dependency.
    function automatic logic idx_hit(
        input logic [REG_ADDR_WIDTH-1:0] ent,
        input logic [REG_ADDR_WIDTH-1:0] idx
    );
        return (idx != '0) && (ent == idx);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the arbiter and its write-back, MDU,
// decode and register-file neighbours.
interface wb_arb_if import wb_arb_pkg::*; #(
    parameter int DW = DATA_WIDTH,
    parameter int AW = REG_ADDR_WIDTH
);

    logic          i_RegWriteW;
    logic [AW-1:0] i_WriteRegW;
    logic [DW-1:0] i_ResultW;

    logic          i_MduValid;
    logic          o_MduReady;
    logic [AW-1:0] i_MduReg;
    logic [DW-1:0] i_MduData;

    logic [AW-1:0] i_RsD;
    logic [AW-1:0] i_RtD;
    logic [AW-1:0] i_RdD;
    logic          o_PendHitD;

    logic          o_RegWrite;
    logic [AW-1:0] o_WriteReg;
    logic [DW-1:0] o_WriteData;
    logic          o_StallReq;
    logic [1:0]    o_PendCount;

    modport master (
        output i_RegWriteW, i_WriteRegW, i_ResultW,
        output i_MduValid, i_MduReg, i_MduData,
        output i_RsD, i_RtD, i_RdD,
        input  o_MduReady, o_PendHitD,
        input  o_RegWrite, o_WriteReg, o_WriteData,
        input  o_StallReq, o_PendCount
    );

    modport slave (
        input  i_RegWriteW, i_WriteRegW, i_ResultW,
        input  i_MduValid, i_MduReg, i_MduData,
        input  i_RsD, i_RtD, i_RdD,
        output o_MduReady, o_PendHitD,
        output o_RegWrite, o_WriteReg, o_WriteData,
        output o_StallReq, o_PendCount
    );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Two-entry FIFO of MDU results waiting for a free write port.
// Exposes per-entry destinations so decode can check against them.
module wb_pending_fifo import wb_arb_pkg::*; (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  pend_entry_t               i_entry,
    output pend_entry_t               o_head,
    output logic [1:0]                o_count,
    output logic [1:0]                o_count_nxt,
    output logic [1:0]                o_valid,
    output logic [REG_ADDR_WIDTH-1:0] o_waddr [2]
);

    pend_entry_t ent_q [2];
    pend_entry_t ent_d [2];
    logic        rd_q, rd_d;
    logic        wr;
    logic [1:0]  cnt_q, cnt_d;
    logic        push, pop;

    assign push = i_push && (cnt_q != 2'd2);
    assign pop  = i_pop && (cnt_q != 2'd0);
    assign wr   = rd_q ^ cnt_q[0];

    always_comb begin
        ent_d = ent_q;
        rd_d  = rd_q;
        if (pop) begin
            ent_d[rd_q].valid = 1'b0;
            rd_d = ~rd_q;
        end
        if (push) begin
            ent_d[wr] = i_entry;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 2; k++) begin
                ent_q[k] <= '0;
            end
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            ent_q <= ent_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        o_head      = ent_q[rd_q];
        o_count     = cnt_q;
        o_count_nxt = cnt_d;
        o_valid     = {ent_q[1].valid, ent_q[0].valid};
        o_waddr[0]  = ent_q[0].waddr;
        o_waddr[1]  = ent_q[1].waddr;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority,
// buffered MDU results drain on free cycles, starvation requests a stall.
module wb_port_arbiter import wb_arb_pkg::*; #(
    parameter int DATA_WIDTH     = wb_arb_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = wb_arb_pkg::REG_ADDR_WIDTH,
    parameter int STARVE_LIMIT   = wb_arb_pkg::STARVE_LIMIT
) (
    input logic     i_clk,
    input logic     i_rst,
    wb_arb_if.slave bus
);

    localparam int            SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    arb_state_t                state_q, state_d;
    logic [SW-1:0]             starve_q, starve_d;
    logic [1:0]                cnt, cnt_nxt;
    logic [1:0]                ent_valid;
    logic [REG_ADDR_WIDTH-1:0] ent_waddr [2];
    pend_entry_t               head, push_ent;
    logic                      pipe_act, drain, push;
    logic                      ready, hit;
    logic [REG_ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;

    assign ready    = (cnt != 2'd2);
    assign pipe_act = bus.i_RegWriteW && (bus.i_WriteRegW != '0);
    assign drain    = !pipe_act && head.valid && !i_rst;
    // Register-0 results are accepted but never stored.
    assign push     = bus.i_MduValid && ready &&
                      (bus.i_MduReg != '0) && !i_rst;
    assign push_ent = '{valid: 1'b1,
                        waddr: bus.i_MduReg,
                        wdata: bus.i_MduData};

    wb_pending_fifo u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_pop       (drain),
        .i_entry     (push_ent),
        .o_head      (head),
        .o_count     (cnt),
        .o_count_nxt (cnt_nxt),
        .o_valid     (ent_valid),
        .o_waddr     (ent_waddr)
    );

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        unique case (1'b1)
            pipe_act: begin
                wr_addr = bus.i_WriteRegW;
                wr_data = bus.i_ResultW;
            end
            drain: begin
                wr_addr = head.waddr;
                wr_data = head.wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (ent_valid[k] &&
                (idx_hit(ent_waddr[k], bus.i_RsD) ||
                 idx_hit(ent_waddr[k], bus.i_RtD) ||
                 idx_hit(ent_waddr[k], bus.i_RdD))) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (drain || cnt_nxt == 2'd0) begin
            starve_d = '0;
        end else if (cnt != 2'd0 && starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (push) state_d = PEND;
            PEND:    if (starve_d == LIMIT) state_d = STARVE;
            STARVE:  if (drain) state_d = PEND;
            default: state_d = IDLE;
        endcase
        if (cnt_nxt == 2'd0) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign bus.o_RegWrite  = pipe_act || drain;
    assign bus.o_WriteReg  = wr_addr;
    assign bus.o_WriteData = wr_data;
    assign bus.o_MduReady  = ready;
    assign bus.o_PendHitD  = hit;
    assign bus.o_PendCount = cnt;
    assign bus.o_StallReq  = (state_q == STARVE);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written
// starvation/reset sequences and random traffic against a queue model.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        mv;
        logic [4:0]  mreg;
        logic [31:0] mdata;
        logic [4:0]  rs, rt, rd;
    } in_t;

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        rdy;
        logic        hit;
        logic        stall;
        logic [1:0]  cnt;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ment_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    in_t   cur;
    ment_t mq[$];
    int    mstarve = 0;
    vec_t  tbl[$];

    wb_arb_if #(.DW(32), .AW(5)) bus ();

    wb_port_arbiter #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic in_t mkin(
        logic rst_i, logic we, logic [4:0] wreg, logic [31:0] wdata,
        logic mv, logic [4:0] mreg, logic [31:0] mdata, logic [4:0] rs
    );
        in_t v;
        v.rst = rst_i; v.we = we; v.wreg = wreg; v.wdata = wdata;
        v.mv = mv; v.mreg = mreg; v.mdata = mdata;
        v.rs = rs; v.rt = 5'd0; v.rd = 5'd0;
        return v;
    endfunction

    function automatic out_t mkout(
        logic we, logic [4:0] wreg, logic [31:0] wdata,
        logic rdy, logic hit, logic stall, logic [1:0] cnt
    );
        out_t e;
        e.we = we; e.wreg = wreg; e.wdata = wdata;
        e.rdy = rdy; e.hit = hit; e.stall = stall; e.cnt = cnt;
        return e;
    endfunction

    task automatic add(input in_t i, input out_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t v);
        cur = v;
        rst = v.rst;
        bus.i_RegWriteW = v.we;
        bus.i_WriteRegW = v.wreg;
        bus.i_ResultW   = v.wdata;
        bus.i_MduValid  = v.mv;
        bus.i_MduReg    = v.mreg;
        bus.i_MduData   = v.mdata;
        bus.i_RsD       = v.rs;
        bus.i_RtD       = v.rt;
        bus.i_RdD       = v.rd;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input out_t e);
        chk({tag, ".we"},    32'(bus.o_RegWrite),  32'(e.we));
        chk({tag, ".wreg"},  32'(bus.o_WriteReg),  32'(e.wreg));
        chk({tag, ".wdata"}, bus.o_WriteData,      e.wdata);
        chk({tag, ".rdy"},   32'(bus.o_MduReady),  32'(e.rdy));
        chk({tag, ".hit"},   32'(bus.o_PendHitD),  32'(e.hit));
        chk({tag, ".stall"}, 32'(bus.o_StallReq),  32'(e.stall));
        chk({tag, ".cnt"},   32'(bus.o_PendCount), 32'(e.cnt));
    endtask

    function automatic logic dep(logic [4:0] r);
        return (cur.rs != 0 && r == cur.rs) ||
               (cur.rt != 0 && r == cur.rt) ||
               (cur.rd != 0 && r == cur.rd);
    endfunction

    // Expected port/status outputs from the pending queue and inputs.
    function automatic out_t model_exp();
        out_t e;
        logic pipe, drn;
        pipe = cur.we && (cur.wreg != 0);
        drn  = !pipe && (mq.size() > 0) && !cur.rst;
        e.we    = pipe || drn;
        e.wreg  = pipe ? cur.wreg  : (drn ? mq[0].r : 5'd0);
        e.wdata = pipe ? cur.wdata : (drn ? mq[0].d : 32'd0);
        e.rdy   = (mq.size() != 2);
        e.hit   = 1'b0;
        foreach (mq[k]) if (dep(mq[k].r)) e.hit = 1'b1;
        e.stall = (mstarve == LIMIT);
        e.cnt   = 2'(mq.size());
        return e;
    endfunction

    task automatic model_step();
        logic  pipe, drn;
        int    old;
        ment_t m;
        pipe = cur.we && (cur.wreg != 0);
        drn  = !pipe && (mq.size() > 0) && !cur.rst;
        old  = mq.size();
        if (cur.rst) begin
            mq.delete();
            mstarve = 0;
        end else begin
            if (drn) void'(mq.pop_front());
            if (cur.mv && old != 2 && cur.mreg != 0) begin
                m.r = cur.mreg;
                m.d = cur.mdata;
                mq.push_back(m);
            end
            if (drn || mq.size() == 0) mstarve = 0;
            else if (old > 0 && mstarve < LIMIT) mstarve++;
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick(input string tag);
        cmp_out(tag, model_exp());
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst we wreg wdata mv mreg mdata rs | we wreg wdata rdy hit stall cnt
        add(mkin(1,0,0,0,0,0,0,0),            mkout(0,0,0,1,0,0,0));
        add(mkin(0,1,8,'h1234,0,0,0,0),       mkout(1,8,'h1234,1,0,0,0));
        add(mkin(0,0,0,0,1,9,'hAAAA,9),       mkout(0,0,0,1,0,0,0));
        add(mkin(0,0,0,0,0,0,0,9),            mkout(1,9,'hAAAA,1,1,0,1));
        add(mkin(0,0,0,0,0,0,0,9),            mkout(0,0,0,1,0,0,0));
        add(mkin(0,1,1,'h11,1,3,'h3333,0),    mkout(1,1,'h11,1,0,0,0));
        add(mkin(0,1,2,'h22,1,4,'h4444,0),    mkout(1,2,'h22,1,0,0,1));
        add(mkin(0,1,5,'h55,0,0,0,4),         mkout(1,5,'h55,0,1,0,2));
        add(mkin(0,1,6,'h66,1,7,'h7777,7),    mkout(1,6,'h66,0,0,0,2));
        add(mkin(0,0,0,0,0,0,0,3),            mkout(1,3,'h3333,0,1,0,2));
        add(mkin(0,0,0,0,0,0,0,3),            mkout(1,4,'h4444,1,0,0,1));
        add(mkin(0,0,0,0,0,0,0,0),            mkout(0,0,0,1,0,0,0));
        add(mkin(0,0,0,0,1,0,'hDEAD,0),       mkout(0,0,0,1,0,0,0));
        add(mkin(0,0,0,0,0,0,0,0),            mkout(0,0,0,1,0,0,0));
        add(mkin(0,0,0,0,1,10,'hBEEF,10),     mkout(0,0,0,1,0,0,0));
        add(mkin(0,1,0,'h999,0,0,0,10),       mkout(1,10,'hBEEF,1,1,0,1));
        add(mkin(0,0,0,0,0,0,0,10),           mkout(0,0,0,1,0,0,0));

        drive(mkin(1,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].i);
            settle();
            cmp_out($sformatf("vec%0d", i), tbl[i].e);
            tick("vec_model");
        end

        // Starvation: one entry held off by back-to-back pipeline writes.
        drive(mkin(0,1,1,'h1,1,12,'hC0DE,0));
        settle();
        tick("stv0");
        for (int k = 1; k <= 7; k++) begin
            drive(mkin(0,1,5'(k + 1),32'(k),0,0,0,0));
            settle();
            chk($sformatf("stv%0d.stall", k), 32'(bus.o_StallReq),
                (k >= 5) ? 32'd1 : 32'd0);
            tick("stv");
        end
        drive(mkin(0,0,0,0,0,0,0,0));
        settle();
        chk("stv_bubble.stall", 32'(bus.o_StallReq), 32'd1);
        chk("stv_bubble.wreg",  32'(bus.o_WriteReg), 32'd12);
        chk("stv_bubble.wdata", bus.o_WriteData,     32'hC0DE);
        tick("stv_bubble");
        settle();
        chk("stv_after.stall", 32'(bus.o_StallReq),  32'd0);
        chk("stv_after.cnt",   32'(bus.o_PendCount), 32'd0);
        tick("stv_after");

        // Reset while full and starving.
        drive(mkin(0,1,1,'h1,1,20,'h20,0));
        settle();
        tick("rst_fill0");
        drive(mkin(0,1,2,'h2,1,21,'h21,0));
        settle();
        tick("rst_fill1");
        for (int k = 2; k <= 6; k++) begin
            drive(mkin(0,1,5'(k + 1),32'(k),0,0,0,0));
            settle();
            tick("rst_hold");
        end
        drive(mkin(0,1,7,'h7,0,0,0,0));
        settle();
        chk("rst_pre.stall", 32'(bus.o_StallReq),  32'd1);
        chk("rst_pre.cnt",   32'(bus.o_PendCount), 32'd2);
        chk("rst_pre.rdy",   32'(bus.o_MduReady),  32'd0);
        tick("rst_pre");
        drive(mkin(1,0,0,0,0,0,0,20));
        settle();
        chk("rst_nodrain.we", 32'(bus.o_RegWrite), 32'd0);
        tick("rst_r1");
        drive(mkin(1,1,8,'h77,0,0,0,20));
        settle();
        chk("rst_pass.we",    32'(bus.o_RegWrite),  32'd1);
        chk("rst_pass.wreg",  32'(bus.o_WriteReg),  32'd8);
        chk("rst_pass.cnt",   32'(bus.o_PendCount), 32'd0);
        chk("rst_pass.stall", 32'(bus.o_StallReq),  32'd0);
        chk("rst_pass.rdy",   32'(bus.o_MduReady),  32'd1);
        chk("rst_pass.hit",   32'(bus.o_PendHitD),  32'd0);
        tick("rst_r2");
        drive(mkin(0,0,0,0,0,0,0,21));
        settle();
        chk("rst_post.we",  32'(bus.o_RegWrite),  32'd0);
        chk("rst_post.cnt", 32'(bus.o_PendCount), 32'd0);
        chk("rst_post.hit", 32'(bus.o_PendHitD),  32'd0);
        tick("rst_post");

        for (int n = 0; n < 1500; n++) begin
            in_t v;
            v.rst   = ($urandom_range(0, 99) == 0);
            v.we    = ($urandom_range(0, 9) < 7);
            v.wreg  = ($urandom_range(0, 3) == 0) ? 5'd0
                      : 5'($urandom_range(1, 31));
            v.wdata = $urandom;
            v.mv    = 1'($urandom_range(0, 1));
            v.mreg  = 5'($urandom_range(0, 7));
            v.mdata = $urandom;
            v.rs    = 5'($urandom_range(0, 7));
            v.rt    = 5'($urandom_range(0, 7));
            v.rd    = 5'($urandom_range(0, 7));
            drive(v);
            settle();
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
